// File: rtl/io_port_bank.sv
// io_port_bank: memory-mapped bank of NUM_PORTS output ports for the FemtoRV32 bus.
// Each port has DATA with SET/CLR/TOG write aliases. Optional per-port hardware
// blink (BLINK_MASK, BLINK_DIV, counter, phase) is compiled in when the macro
// IO_PORT_BANK_BLINK_EN is defined; without it port_out is simply DATA.
// Bus handshake: the bank never stalls (mem_rbusy/mem_wbusy are 0); a write is
// accepted on any rising edge where the address is selected and mem_wmask != 0,
// and a read strobe loads mem_rdata on its edge, which holds until the next
// selected strobe.
module io_port_bank #(
  parameter int NUM_PORTS = 2,
  parameter int PORT_WIDTH = 8,
  parameter logic [PORT_WIDTH-1:0] RESET_VALUE = '0,
  parameter int IO_BIT = 22
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [31:0]                     mem_addr,
  input  logic [31:0]                     mem_wdata,
  input  logic [3:0]                      mem_wmask,
  input  logic                            mem_rstrb,
  output logic [31:0]                     mem_rdata,
  output logic                            mem_rbusy,
  output logic                            mem_wbusy,
  output logic [NUM_PORTS*PORT_WIDTH-1:0] port_out
);

  localparam int PW = PORT_WIDTH;

  logic          sel;
  logic [2:0]    port_idx;
  logic [2:0]    reg_idx;
  logic          port_ok;
  logic          wr_en;
  logic          rd_en;
  logic          data_wr;
  logic [31:0]   byte_mask;
  logic [31:0]   wbits;
  logic [PW-1:0] data_q [NUM_PORTS];
  logic [PW-1:0] cur_data;
  logic [31:0]   data_ext;
  logic [31:0]   data_new_ext;
  logic [PW-1:0] data_next;
  logic [31:0]   rd_value;
  logic          unused_bits;

  assign mem_rbusy = 1'b0;
  assign mem_wbusy = 1'b0;

  // Address decode and byte-lane write data
  always_comb begin
    sel       = mem_addr[IO_BIT];
    port_idx  = mem_addr[7:5];
    reg_idx   = mem_addr[4:2];
    port_ok   = ({1'b0, port_idx} < 4'(NUM_PORTS));
    wr_en     = sel && (mem_wmask != 4'b0000) && port_ok;
    rd_en     = sel && mem_rstrb;
    byte_mask = {{8{mem_wmask[3]}}, {8{mem_wmask[2]}}, {8{mem_wmask[1]}}, {8{mem_wmask[0]}}};
    wbits     = mem_wdata & byte_mask;
  end

  // Select the addressed port's DATA and compute its post-write value
  always_comb begin
    cur_data = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_idx == 3'(p)) cur_data = data_q[p];
    end
    data_ext = 32'(cur_data);
    case (reg_idx)
      3'd0:    data_new_ext = (data_ext & ~byte_mask) | wbits;
      3'd1:    data_new_ext = data_ext | wbits;
      3'd2:    data_new_ext = data_ext & ~wbits;
      3'd3:    data_new_ext = data_ext ^ wbits;
      default: data_new_ext = data_ext;
    endcase
    data_next = data_new_ext[PW-1:0];
    data_wr   = wr_en && (reg_idx <= 3'd3);
  end

  // DATA registers: one per port, updated only by writes to registers 0-3
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) data_q[p] <= RESET_VALUE;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (data_wr && (port_idx == 3'(p))) data_q[p] <= data_next;
      end
    end
  end

`ifdef IO_PORT_BANK_BLINK_EN
  logic [PW-1:0] mask_q  [NUM_PORTS];
  logic [23:0]   div_q   [NUM_PORTS];
  logic [23:0]   cnt_q   [NUM_PORTS];
  logic          phase_q [NUM_PORTS];
  logic [PW-1:0] cur_mask;
  logic [23:0]   cur_div;
  logic [31:0]   mask_new_ext;
  logic [31:0]   div_new_ext;
  logic          mask_wr;
  logic          div_wr;
  logic          unused_blink;

  // Select the addressed port's blink settings and compute post-write values
  always_comb begin
    cur_mask = '0;
    cur_div  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (port_idx == 3'(p)) begin
        cur_mask = mask_q[p];
        cur_div  = div_q[p];
      end
    end
    mask_new_ext = (32'(cur_mask) & ~byte_mask) | wbits;
    div_new_ext  = (32'(cur_div) & ~byte_mask) | wbits;
    mask_wr      = wr_en && (reg_idx == 3'd4);
    div_wr       = wr_en && (reg_idx == 3'd5);
  end

  // Blink settings registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        mask_q[p] <= '0;
        div_q[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (mask_wr && (port_idx == 3'(p))) mask_q[p] <= mask_new_ext[PW-1:0];
        if (div_wr && (port_idx == 3'(p)))  div_q[p]  <= div_new_ext[23:0];
      end
    end
  end

  // Blink counters: count 0..BLINK_DIV then wrap and flip phase; DIV=0 or a DIV write parks at 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        cnt_q[p]   <= '0;
        phase_q[p] <= 1'b0;
      end
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if ((div_wr && (port_idx == 3'(p))) || (div_q[p] == 24'd0)) begin
          cnt_q[p]   <= '0;
          phase_q[p] <= 1'b0;
        end else if (cnt_q[p] >= div_q[p]) begin
          cnt_q[p]   <= '0;
          phase_q[p] <= ~phase_q[p];
        end else begin
          cnt_q[p] <= cnt_q[p] + 24'd1;
        end
      end
    end
  end

  // Port outputs: DATA with masked bits inverted during the odd blink phase
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_out[p*PW +: PW] = data_q[p] ^ (mask_q[p] & {PW{phase_q[p]}});
    end
  end

  assign unused_blink = ^{mask_new_ext, div_new_ext};
`else
  // Port outputs: DATA drives the pins directly
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      port_out[p*PW +: PW] = data_q[p];
    end
  end
`endif

  // Read mux: pre-write register contents of the addressed port
  always_comb begin
    rd_value = 32'd0;
    if (port_ok) begin
      case (reg_idx)
        3'd0, 3'd1, 3'd2, 3'd3: rd_value = data_ext;
`ifdef IO_PORT_BANK_BLINK_EN
        3'd4:                   rd_value = 32'(cur_mask);
        3'd5:                   rd_value = 32'(cur_div);
`endif
        default:                rd_value = 32'd0;
      endcase
    end
  end

  // Registered read data, loaded only on a selected read strobe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) mem_rdata <= 32'd0;
    else if (rd_en) mem_rdata <= rd_value;
  end

  // Address/data bits outside the decoded fields are intentionally ignored
  assign unused_bits = ^{mem_addr, mem_wdata, data_new_ext};

endmodule

// File: tb/tb_io_port_bank.sv
// tb_io_port_bank: scenario tasks with a read-data expectation queue for io_port_bank.
module tb_io_port_bank;

  localparam int NP = 2;
  localparam int PW = 8;
  localparam logic [7:0] RV = 8'h00;

  logic        clk;
  logic        reset;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_rstrb;
  logic [31:0] mem_rdata;
  logic        mem_rbusy;
  logic        mem_wbusy;
  logic [15:0] port_out;

  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  int          vec_cnt;
  int          err_cnt;
  logic [7:0]  data_m [NP];
  logic [31:0] last_rd;

  io_port_bank #(
    .NUM_PORTS(NP), .PORT_WIDTH(PW), .RESET_VALUE(RV), .IO_BIT(22)
  ) dut (
    .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata),
    .mem_rbusy(mem_rbusy), .mem_wbusy(mem_wbusy), .port_out(port_out)
  );

  // clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, got no finish, need finish");
    $fatal(1, "watchdog");
  end

  // driver: present one bus cycle at the falling edge, return 1 time unit after the capture edge
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m, input logic r);
    @(negedge clk);
    mem_addr  = a;
    mem_wdata = d;
    mem_wmask = m;
    mem_rstrb = r;
    @(posedge clk);
    #1;
    mem_wmask = 4'h0;
    mem_rstrb = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vec_cnt++;
    if (port_out !== {RV, RV}) begin err_cnt++; $display("FAIL reset_port_out: got %h need %h", port_out, {RV, RV}); end
    vec_cnt++;
    if (mem_rdata !== 32'd0) begin err_cnt++; $display("FAIL reset_rdata: got %h need 0", mem_rdata); end
    vec_cnt++;
    if ((mem_rbusy !== 1'b0) || (mem_wbusy !== 1'b0)) begin err_cnt++; $display("FAIL busy_tied: got %b%b need 00", mem_rbusy, mem_wbusy); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    vec_cnt++;
    if (port_out !== {RV, RV}) begin err_cnt++; $display("FAIL post_reset_port_out: got %h need %h", port_out, {RV, RV}); end
  endtask

  task automatic test_set_tog();
    drive(32'h0040_0000, 32'h0000_00A5, 4'hF, 1'b0);
    vec_cnt++;
    if (port_out !== 16'h00A5) begin err_cnt++; $display("FAIL data_write: got %h need 00a5", port_out); end
    drive(32'h0040_0004, 32'h0000_000F, 4'hF, 1'b0);
    vec_cnt++;
    if (port_out !== 16'h00AF) begin err_cnt++; $display("FAIL set: got %h need 00af", port_out); end
    drive(32'h0040_000C, 32'h0000_00FF, 4'hF, 1'b0);
    vec_cnt++;
    if (port_out !== 16'h0050) begin err_cnt++; $display("FAIL tog: got %h need 0050", port_out); end
  endtask

  task automatic test_read();
    drive(32'h0040_0020, 32'h0000_003C, 4'hF, 1'b0);
    vec_cnt++;
    if (port_out !== 16'h3C50) begin err_cnt++; $display("FAIL port1_write: got %h need 3c50", port_out); end
    // port1 via CLR alias, invalid port 7, register 4, register 6
    exp_q.push_back(32'h3C);
    drive(32'h0040_0028, 32'h0, 4'h0, 1'b1);
    exp_v = exp_q.pop_front();
    vec_cnt++;
    if (mem_rdata !== exp_v) begin err_cnt++; $display("FAIL read_port1: got %h need %h", mem_rdata, exp_v); end
    exp_q.push_back(32'h0);
    drive(32'h0040_00E0, 32'h0, 4'h0, 1'b1);
    exp_v = exp_q.pop_front();
    vec_cnt++;
    if (mem_rdata !== exp_v) begin err_cnt++; $display("FAIL read_bad_port: got %h need %h", mem_rdata, exp_v); end
    exp_q.push_back(32'h3C);
    drive(32'h0040_0020, 32'h0, 4'h0, 1'b1);
    exp_v = exp_q.pop_front();
    exp_q.push_back(32'h0);
    drive(32'h0040_0030, 32'h0, 4'h0, 1'b1);
    exp_v = exp_q.pop_front();
    vec_cnt++;
    if (mem_rdata !== exp_v) begin err_cnt++; $display("FAIL read_reg4: got %h need %h", mem_rdata, exp_v); end
    exp_q.push_back(32'h50);
    drive(32'h0040_0000, 32'h0, 4'h0, 1'b1);
    exp_v = exp_q.pop_front();
    exp_q.push_back(32'h0);
    drive(32'h0040_0018, 32'h0, 4'h0, 1'b1);
    exp_v = exp_q.pop_front();
    vec_cnt++;
    if (mem_rdata !== exp_v) begin err_cnt++; $display("FAIL read_reg6: got %h need %h", mem_rdata, exp_v); end
  endtask

  task automatic test_ignore();
    drive(32'h0000_0000, 32'h0000_00FF, 4'hF, 1'b0);
    vec_cnt++;
    if (port_out !== 16'h3C50) begin err_cnt++; $display("FAIL unselected_write: got %h need 3c50", port_out); end
    drive(32'h0040_0000, 32'hFFFF_FF00, 4'h2, 1'b0);
    vec_cnt++;
    if (port_out !== 16'h3C50) begin err_cnt++; $display("FAIL upper_lane_write: got %h need 3c50", port_out); end
    drive(32'h0040_00E0, 32'h0000_00FF, 4'hF, 1'b0);
    drive(32'h0040_0018, 32'h0000_00FF, 4'hF, 1'b0);
    drive(32'h0040_0038, 32'h0000_00FF, 4'hF, 1'b0);
    vec_cnt++;
    if (port_out !== 16'h3C50) begin err_cnt++; $display("FAIL ignored_regs: got %h need 3c50", port_out); end
    // unselected read strobe must leave mem_rdata alone
    exp_q.push_back(32'h3C);
    drive(32'h0040_0024, 32'h0, 4'h0, 1'b1);
    exp_v = exp_q.pop_front();
    exp_q.push_back(32'h3C);
    drive(32'h0000_0000, 32'h0, 4'h0, 1'b1);
    exp_v = exp_q.pop_front();
    vec_cnt++;
    if (mem_rdata !== exp_v) begin err_cnt++; $display("FAIL rdata_hold: got %h need %h", mem_rdata, exp_v); end
`ifndef IO_PORT_BANK_BLINK_EN
    drive(32'h0040_0010, 32'h0000_00FF, 4'hF, 1'b0);
    drive(32'h0040_0014, 32'h00FF_FFFF, 4'hF, 1'b0);
    exp_q.push_back(32'h0);
    drive(32'h0040_0014, 32'h0, 4'h0, 1'b1);
    exp_v = exp_q.pop_front();
    vec_cnt++;
    if (mem_rdata !== exp_v) begin err_cnt++; $display("FAIL reg5_absent: got %h need %h", mem_rdata, exp_v); end
    vec_cnt++;
    if (port_out !== 16'h3C50) begin err_cnt++; $display("FAIL no_blink: got %h need 3c50", port_out); end
`endif
  endtask

  task automatic test_rw_same();
    exp_q.push_back(32'h50);
    drive(32'h0040_0000, 32'h0000_0099, 4'hF, 1'b1);
    exp_v = exp_q.pop_front();
    vec_cnt++;
    if (mem_rdata !== exp_v) begin err_cnt++; $display("FAIL rw_same_read: got %h need %h", mem_rdata, exp_v); end
    vec_cnt++;
    if (port_out !== 16'h3C99) begin err_cnt++; $display("FAIL rw_same_write: got %h need 3c99", port_out); end
    drive(32'h0040_0023, 32'h1234_5677, 4'h1, 1'b0);
    vec_cnt++;
    if (port_out !== 16'h7799) begin err_cnt++; $display("FAIL byte0_write: got %h need 7799", port_out); end
    drive(32'h0040_0028, 32'h0000_0007, 4'h1, 1'b0);
    vec_cnt++;
    if (port_out !== 16'h7099) begin err_cnt++; $display("FAIL clr: got %h need 7099", port_out); end
  endtask

  task automatic test_random();
    logic [31:0] a, d, bm, ext, nv;
    logic [3:0]  m;
    logic        r, s;
    int          pi, ri;
    data_m[0] = 8'h99;
    data_m[1] = 8'h70;
    exp_q.push_back(32'h99);
    drive(32'h0040_0000, 32'h0, 4'h0, 1'b1);
    exp_v = exp_q.pop_front();
    last_rd = 32'h99;
    for (int i = 0; i < 60; i++) begin
      s  = ($urandom_range(0, 7) != 0);
      pi = $urandom_range(0, 3);
      ri = $urandom_range(0, 5);
`ifdef IO_PORT_BANK_BLINK_EN
      if (ri >= 4) ri = ri + 2;
`else
      if ($urandom_range(0, 1) == 1) ri = ri + 2;
`endif
      a  = {9'd0, s, 14'd0, 3'(pi), 3'(ri), 2'($urandom_range(0, 3))};
      d  = $urandom;
      m  = 4'($urandom_range(0, 15));
      r  = ($urandom_range(0, 1) == 1);
      bm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
      // expected read uses the pre-write model state
      if (r && s) begin
        if (pi < NP && ri <= 3) last_rd = {24'd0, data_m[pi]};
        else last_rd = 32'd0;
      end
      exp_q.push_back(last_rd);
      if (s && (m != 4'h0) && pi < NP && ri <= 3) begin
        ext = {24'd0, data_m[pi]};
        case (ri)
          0:       nv = (ext & ~bm) | (d & bm);
          1:       nv = ext | (d & bm);
          2:       nv = ext & ~(d & bm);
          default: nv = ext ^ (d & bm);
        endcase
        data_m[pi] = nv[7:0];
      end
      drive(a, d, m, r);
      if (exp_q.size() == 0) begin
        err_cnt++; vec_cnt++;
        $display("FAIL rand_queue: got empty queue need entry");
      end else begin
        exp_v = exp_q.pop_front();
        vec_cnt++;
        if (mem_rdata !== exp_v) begin err_cnt++; $display("FAIL rand_rdata[%0d]: got %h need %h", i, mem_rdata, exp_v); end
      end
      vec_cnt++;
      if (port_out !== {data_m[1], data_m[0]}) begin
        err_cnt++; $display("FAIL rand_port_out[%0d]: got %h need %h", i, port_out, {data_m[1], data_m[0]});
      end
    end
  endtask

`ifdef IO_PORT_BANK_BLINK_EN
  task automatic test_blink();
    logic b;
    drive(32'h0040_0000, 32'h0000_0000, 4'hF, 1'b0);
    drive(32'h0040_0010, 32'h0000_0001, 4'hF, 1'b0);
    drive(32'h0040_0014, 32'h0000_0003, 4'hF, 1'b0);
    vec_cnt++;
    if (port_out[0] !== 1'b0) begin err_cnt++; $display("FAIL blink_start: got %b need 0", port_out[0]); end
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      b = ((k / 4) % 2) == 1;
      vec_cnt++;
      if (port_out[7:0] !== {7'd0, b}) begin err_cnt++; $display("FAIL blink_cycle[%0d]: got %h need %h", k, port_out[7:0], {7'd0, b}); end
    end
    exp_q.push_back(32'h1);
    drive(32'h0040_0010, 32'h0, 4'h0, 1'b1);
    exp_v = exp_q.pop_front();
    vec_cnt++;
    if (mem_rdata !== exp_v) begin err_cnt++; $display("FAIL read_mask: got %h need %h", mem_rdata, exp_v); end
    exp_q.push_back(32'h3);
    drive(32'h0040_0014, 32'h0, 4'h0, 1'b1);
    exp_v = exp_q.pop_front();
    vec_cnt++;
    if (mem_rdata !== exp_v) begin err_cnt++; $display("FAIL read_div: got %h need %h", mem_rdata, exp_v); end
    drive(32'h0040_0014, 32'h0000_0000, 4'hF, 1'b0);
    for (int k = 0; k < 6; k++) begin
      vec_cnt++;
      if (port_out[0] !== 1'b0) begin err_cnt++; $display("FAIL blink_frozen[%0d]: got %b need 0", k, port_out[0]); end
      @(posedge clk);
      #1;
    end
    drive(32'h0040_0014, 32'h0000_0003, 4'hF, 1'b0);
  endtask
`endif

  task automatic test_reset_async();
    drive(32'h0040_0000, 32'h0000_0055, 4'hF, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    mem_addr  = 32'h0040_0000;
    mem_wdata = 32'h0000_00FF;
    mem_wmask = 4'hF;
    #2;
    reset = 1'b1;
    #1;
    vec_cnt++;
    if (port_out !== {RV, RV}) begin err_cnt++; $display("FAIL async_reset: got %h need %h", port_out, {RV, RV}); end
    vec_cnt++;
    if (mem_rdata !== 32'd0) begin err_cnt++; $display("FAIL async_reset_rdata: got %h need 0", mem_rdata); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    mem_wmask = 4'h0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      vec_cnt++;
      if (port_out !== {RV, RV}) begin err_cnt++; $display("FAIL after_reset[%0d]: got %h need %h", k, port_out, {RV, RV}); end
    end
  endtask

  initial begin
    vec_cnt   = 0;
    err_cnt   = 0;
    reset     = 1'b1;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wmask = 4'h0;
    mem_rstrb = 1'b0;
    test_reset();
    test_set_tog();
    test_read();
    test_ignore();
    test_rw_same();
    test_random();
`ifdef IO_PORT_BANK_BLINK_EN
    test_blink();
`endif
    test_reset_async();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
